// File: rtl/spike_delay_line_if.sv
// Bundle of the time-step, spike and delay-configuration signals of the
// spike delay line. The optional flush line is present only when
// SPIKE_DELAY_FLUSH_EN is defined.
interface spike_delay_line_if #(
    parameter int M  = 8,
    parameter int DW = 3
);
    logic              enable;
    logic [M-1:0]      input_spikes;
    logic [M*DW-1:0]   delays;
    logic              delay_load;
    logic [M-1:0]      delayed_spikes;
    logic              pending;
`ifdef SPIKE_DELAY_FLUSH_EN
    logic              flush;

    modport master (
        output enable, input_spikes, delays, delay_load, flush,
        input  delayed_spikes, pending
    );
    modport slave (
        input  enable, input_spikes, delays, delay_load, flush,
        output delayed_spikes, pending
    );
`else
    modport master (
        output enable, input_spikes, delays, delay_load,
        input  delayed_spikes, pending
    );
    modport slave (
        input  enable, input_spikes, delays, delay_load,
        output delayed_spikes, pending
    );
`endif
endinterface

// File: rtl/spike_delay_line.sv
// Per-synapse programmable axonal delay ahead of the LIF neuron.
// Each of the M spike lines is re-emitted after its own delay, counted in
// enable (time-step) strobes. A delay of 0 is a one-clock registered
// pass-through. Optional macro SPIKE_DELAY_FLUSH_EN adds a flush input that
// wipes in-flight spikes while keeping the loaded delays.
module spike_delay_line #(
    parameter int M  = 8,
    parameter int DW = 3
) (
    input  logic                clk,
    input  logic                reset,
    spike_delay_line_if.slave   bus
);
    localparam int MAX_DELAY = (1 << DW) - 1;

    logic [DW-1:0]        r_delay    [M];
    logic [MAX_DELAY:1]   r_hist     [M];
    logic [M-1:0]         r_out;
    logic                 r_pending;

    // Bit 0 is the current input, bits 1..MAX_DELAY the history, so a delay
    // value indexes its tap directly and delay 0 selects the live input.
    logic [MAX_DELAY:0]   w_ext      [M];
    logic [MAX_DELAY:1]   w_hist_nxt [M];
    logic [M-1:0]         w_tap;
    logic                 w_clear;
    logic                 w_advance;
    logic                 w_any;

    // Flush (when built in) wins over a time step on the same edge.
    always_comb begin
`ifdef SPIKE_DELAY_FLUSH_EN
        w_clear = bus.flush;
`else
        w_clear = 1'b0;
`endif
        w_advance = bus.enable & ~w_clear;
    end

    // Tap selection (before the shift) and next history per line.
    always_comb begin
        w_any = 1'b0;
        for (int i = 0; i < M; i++) begin
            w_ext[i] = {r_hist[i], bus.input_spikes[i]};
            w_tap[i] = w_ext[i][r_delay[i]];
            if (w_clear) begin
                w_hist_nxt[i] = '0;
            end else if (w_advance) begin
                w_hist_nxt[i] = w_ext[i][MAX_DELAY-1:0];
            end else begin
                w_hist_nxt[i] = r_hist[i];
            end
            w_any = w_any | (|w_hist_nxt[i]);
        end
    end

    // Delay registers, history shift, registered output and pending flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < M; i++) begin
                r_delay[i] <= '0;
                r_hist[i]  <= '0;
            end
            r_out     <= '0;
            r_pending <= 1'b0;
        end else begin
            for (int i = 0; i < M; i++) begin
                if (bus.delay_load) begin
                    r_delay[i] <= bus.delays[i*DW +: DW];
                end
                r_hist[i] <= w_hist_nxt[i];
            end
            if (w_clear) begin
                r_out <= '0;
            end else if (w_advance) begin
                r_out <= w_tap;
            end
            r_pending <= w_any;
        end
    end

    assign bus.delayed_spikes = r_out;
    assign bus.pending        = r_pending;

endmodule

// File: tb/tb_spike_delay_line.sv
module tb_spike_delay_line;
    localparam int M  = 8;
    localparam int DW = 3;

    typedef struct {
        logic [M-1:0] out;
        logic         pend;
        string        name;
    } exp_t;

    logic clk;
    logic reset;
    exp_t q[$];
    int   n_cmp;
    int   n_bad;

    spike_delay_line_if #(.M(M), .DW(DW)) bus ();

    spike_delay_line #(.M(M), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [M-1:0] got_out,
                         input logic [M-1:0] exp_out, input logic got_p,
                         input logic exp_p);
        n_cmp++;
        if (got_out !== exp_out) begin
            n_bad++;
            $display("FAIL %s delayed_spikes got %h want %h", name, got_out, exp_out);
        end
        n_cmp++;
        if (got_p !== exp_p) begin
            n_bad++;
            $display("FAIL %s pending got %b want %b", name, got_p, exp_p);
        end
    endtask

    // Monitor: one expectation is consumed after every rising edge it was queued for.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check(e.name, bus.delayed_spikes, e.out, bus.pending, e.pend);
        end
    end

    task automatic cyc(input string name, input logic en, input logic [M-1:0] spk,
                       input logic ld, input logic [M*DW-1:0] dly, input logic fl,
                       input logic [M-1:0] exp_out, input logic exp_p);
        exp_t e;
        @(negedge clk);
        bus.enable       = en;
        bus.input_spikes = spk;
        bus.delay_load   = ld;
        bus.delays       = dly;
`ifdef SPIKE_DELAY_FLUSH_EN
        bus.flush        = fl;
`else
        if (fl) $display("FAIL %s flush requested without flush build", name);
`endif
        e.out  = exp_out;
        e.pend = exp_p;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step(input string name, input logic [M-1:0] spk,
                        input logic [M-1:0] exp_out, input logic exp_p);
        cyc(name, 1'b1, spk, 1'b0, '0, 1'b0, exp_out, exp_p);
    endtask

    task automatic idle(input string name, input logic [M-1:0] spk,
                        input logic [M-1:0] exp_out, input logic exp_p);
        cyc(name, 1'b0, spk, 1'b0, '0, 1'b0, exp_out, exp_p);
    endtask

    task automatic load(input string name, input logic [M*DW-1:0] dly,
                        input logic [M-1:0] exp_out, input logic exp_p);
        cyc(name, 1'b0, '0, 1'b1, dly, 1'b0, exp_out, exp_p);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        bus.enable       = 1'b0;
        bus.delay_load   = 1'b0;
        bus.input_spikes = '0;
`ifdef SPIKE_DELAY_FLUSH_EN
        bus.flush        = 1'b0;
`endif
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never consumed", q.size());
            q.delete();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.enable       = 1'b0;
        bus.input_spikes = '0;
        bus.delays       = '0;
        bus.delay_load   = 1'b0;
`ifdef SPIKE_DELAY_FLUSH_EN
        bus.flush        = 1'b0;
`endif
        #1;
        check("reset_state", bus.delayed_spikes, 8'h00, bus.pending, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset mid-operation: all delays 3, spikes in flight, async reset.
        load("rst_load", 24'h6DB6DB, 8'h00, 1'b0);
        step("rst_s0", 8'hFF, 8'h00, 1'b1);
        step("rst_s1", 8'h00, 8'h00, 1'b1);
        step("rst_s2", 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        bus.enable = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", bus.delayed_spikes, 8'h00, bus.pending, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Per-line latency: line i has delay i.
        load("lat_load", 24'hFAC688, 8'h00, 1'b0);
        step("lat_s0", 8'hFF, 8'h01, 1'b1);
        step("lat_s1", 8'h00, 8'h02, 1'b1);
        step("lat_s2", 8'h00, 8'h04, 1'b1);
        step("lat_s3", 8'h00, 8'h08, 1'b1);
        step("lat_s4", 8'h00, 8'h10, 1'b1);
        step("lat_s5", 8'h00, 8'h20, 1'b1);
        step("lat_s6", 8'h00, 8'h40, 1'b1);
        step("lat_s7", 8'h00, 8'h80, 1'b0);
        step("lat_s8", 8'h00, 8'h00, 1'b0);

        // Enable gating: line 0 delay 2, idle clocks carry ignored spikes.
        load("gate_load", 24'h000002, 8'h00, 1'b0);
        step("gate_s0", 8'h01, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) idle("gate_idle0", 8'h01, 8'h00, 1'b1);
        step("gate_s1", 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) idle("gate_idle1", 8'hFF, 8'h00, 1'b1);
        step("gate_s2", 8'h00, 8'h01, 1'b1);
        for (int k = 0; k < 5; k++) idle("gate_idle2", 8'h00, 8'h01, 1'b1);
        step("gate_s3", 8'h00, 8'h00, 1'b1);
        step("gate_s4", 8'h00, 8'h00, 1'b1);
        step("gate_s5", 8'h00, 8'h00, 1'b1);
        step("gate_s6", 8'h00, 8'h00, 1'b1);
        step("gate_s7", 8'h00, 8'h00, 1'b0);

        // Load collision: delay 1 -> 4 loaded on the same edge as a step.
        load("coll_load", 24'h000001, 8'h00, 1'b0);
        step("coll_s0", 8'h01, 8'h00, 1'b1);
        cyc("coll_s1", 1'b1, 8'h00, 1'b1, 24'h000004, 1'b0, 8'h01, 1'b1);
        step("coll_s2", 8'h01, 8'h00, 1'b1);
        step("coll_s3", 8'h00, 8'h00, 1'b1);
        step("coll_s4", 8'h00, 8'h01, 1'b1);
        step("coll_s5", 8'h00, 8'h00, 1'b1);
        step("coll_s6", 8'h00, 8'h01, 1'b1);
        step("coll_s7", 8'h00, 8'h00, 1'b1);
        step("coll_s8", 8'h00, 8'h00, 1'b1);
        step("coll_s9", 8'h00, 8'h00, 1'b0);

        // Continuous train: line 3 delay 7, spikes for 10 steps.
        load("train_load", 24'h000E00, 8'h00, 1'b0);
        for (int s = 0; s < 18; s++) begin
            step($sformatf("train_s%0d", s),
                 (s < 10) ? 8'h08 : 8'h00,
                 (s >= 7 && s <= 16) ? 8'h08 : 8'h00,
                 (s <= 15) ? 1'b1 : 1'b0);
        end

`ifdef SPIKE_DELAY_FLUSH_EN
        // Flush with spikes in flight, together with enable.
        load("fl_load", 24'h000002, 8'h00, 1'b0);
        step("fl_s0", 8'h01, 8'h00, 1'b1);
        step("fl_s1", 8'h00, 8'h00, 1'b1);
        cyc("fl_flush", 1'b1, 8'h01, 1'b0, '0, 1'b1, 8'h00, 1'b0);
        for (int s = 2; s < 9; s++) step($sformatf("fl_s%0d", s), 8'h00, 8'h00, 1'b0);
        // Delay register survives flush: single-step pass-through still delay 2.
        step("fl_chk0", 8'h01, 8'h00, 1'b1);
        step("fl_chk1", 8'h00, 8'h00, 1'b1);
        step("fl_chk2", 8'h00, 8'h01, 1'b1);
`endif

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spike_delay_line.md
Name: spike_delay_line

Overview:
- Programmable per-synapse axonal delay stage that sits directly upstream of the LIF neuron.
- Takes M raw presynaptic spike lines and re-emits each one after its own configured number of time steps.
- Its delayed_spikes output feeds the neuron's input_spikes port.
- Advances only on enable, the same time-step strobe that drives the neuron, so delays are counted in time steps, not clocks.

Parameters:
- M, 8, number of synapse lines.
- DW, 3, bit width of each delay value. MAX_DELAY = 2^DW-1 is a derived localparam (7 at default).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state.
- enable  input  1  time-step strobe; history and outputs advance only when high.
- input_spikes  input  M  raw spikes for the current time step, sampled when enable=1.
- delays  input  M*DW  packed delay values; line i uses bits [i*DW +: DW].
- delay_load  input  1  single-cycle strobe; captures delays into the internal delay registers.
- delayed_spikes  output  M  registered delayed spikes, to the neuron's input_spikes.
- pending  output  1  high while any spike is still held in any history register.

Behaviour:
- Reset (reset=0, asynchronous):
  - history cleared.
  - delay_reg cleared, so every line has delay 0.
  - delayed_spikes=0, pending=0.
  - Normal operation resumes on the first rising edge after reset returns high.
- State per line i:
  - hist_i[1..MAX_DELAY] shift register.
  - delay_reg_i, DW bits.
- On a rising edge with enable=1, for each line i, in this order:
  - delayed_spikes[i] <= input_spikes[i] if delay_reg_i==0, else hist_i[delay_reg_i]. The tap is read before the shift.
  - hist_i[1] <= input_spikes[i]; hist_i[k] <= hist_i[k-1] for k=2..MAX_DELAY. The oldest bit is discarded.
- Latency:
  - A spike presented at enable step t appears on delayed_spikes from the clock edge of step t+delay.
  - It stays visible until the next enable edge.
  - Delay 0 is a one-clock registered pass-through.
- enable=0: history and delayed_spikes are held unchanged, and input_spikes is ignored.
- delay_load:
  - On a rising edge with delay_load=1, delay_reg <= delays for all lines.
  - The history is not disturbed, so spikes already in flight are re-timed against the new tap.
  - Spikes older than the new tap are never emitted; spikes younger than it can be emitted, and emitted twice if the tap moves later.
- delay_load and enable on the same edge: the output tap uses the old delay_reg; the new values apply from the next enable edge.
- Duplicate spikes on one line are not merged across steps. A spike on every step produces delayed_spikes[i]=1 on every step once the pipe has filled.
- pending:
  - Registered: the OR of all history bits after the update.
  - Cleared by reset, or once MAX_DELAY enable steps pass with no input spikes.
- Widths: no arithmetic. Every DW-bit delay value is legal, and MAX_DELAY bounds the history exactly, so no out-of-range case exists.

Optional Feature:
- Macro: SPIKE_DELAY_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - On a rising edge with flush=1, all history bits, delayed_spikes and pending clear to 0; delay_reg is kept.
  - flush overrides enable on the same edge.
  - delay_load still takes effect on a flush edge.
- When not defined: no flush port exists, and history is cleared only by reset.

Test Plan:
- Reset mid-operation: load delays all 3, inject spikes, assert reset=0 between clock edges -> delayed_spikes=0 and pending=0 immediately, with no clock edge needed.
- Per-line latency, M=8: delays={7,6,5,4,3,2,1,0} (line7=7 ... line0=0), pulse delay_load, then one enable step with input_spikes=8'hFF followed by zeros -> delayed_spikes = 8'h01, 02, 04, ..., 80 on successive enable steps, then 0. pending falls after step 7.
- Enable gating: delay 2 on line 0, spike at step 0, enable low for 5 clocks between steps -> output fires exactly at enable step 2; output and history are unchanged during the idle clocks.
- Load collision: line 0 delay 1, spike injected; on the next enable edge also pulse delay_load with delay 4 -> output fires at step 1 (old tap); a new spike injected afterwards appears 4 steps later.
- Continuous train: line 3 delay 7, input_spikes[3]=1 for 10 steps -> output 0 for steps 0-6, 1 for steps 7-16, then 0; pending deasserts 7 steps after the last input.
- With SPIKE_DELAY_FLUSH_EN: spikes in flight, flush=1 together with enable=1 -> next cycle delayed_spikes=0 and pending=0, and the old spikes never emerge.
